// File: rtl/multi_mode_timer.sv
// ---------------------------------------------------------------------------
// multi_mode_timer
//
// Minutes:seconds timer with countdown and stopwatch modes, driven by seven
// debounced pushbuttons.
//
// Buttons are expected to be synchronous to clk. Debounce counts whole clk
// cycles, so any synchronizer stage belongs upstream of this block.
//
// Parameters
//   TICK_CYCLES  clk cycles per 1 s tick (>= 2)
//   DEB_CYCLES   consecutive high cycles before a press is accepted (>= 1)
//   MAX_MIN      highest minutes value (1..99)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start, edit, edit_shift, inc, dec, clear, mode_sel
//               pushbuttons, active high
//   minutes     current minutes, 0..MAX_MIN
//   seconds     current seconds, 0..59
//   state       IDLE=0, EDIT=1, RUN=2, PAUSED=3, EXPIRED=4
//   count_up    0 = countdown, 1 = stopwatch
//   edit_place  1 = minutes field selected, 0 = seconds field selected
//   done        one-cycle pulse on entry to EXPIRED
//   alarm       high while in EXPIRED
//   btn_ack     high from the accepting cycle until all buttons are low
// ---------------------------------------------------------------------------
module multi_mode_timer #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int DEB_CYCLES  = 25_000_000,
    parameter int MAX_MIN     = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       edit,
    input  logic       edit_shift,
    input  logic       inc,
    input  logic       dec,
    input  logic       clear,
    input  logic       mode_sel,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic [2:0] state,
    output logic       count_up,
    output logic       edit_place,
    output logic       done,
    output logic       alarm,
    output logic       btn_ack
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EDIT    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_PAUSED  = 3'd3;
    localparam logic [2:0] S_EXPIRED = 3'd4;

    // Button indices double as priority order: lower index wins.
    localparam int NB         = 7;
    localparam int B_CLEAR    = 0;
    localparam int B_EDIT     = 1;
    localparam int B_START    = 2;
    localparam int B_SHIFT    = 3;
    localparam int B_INC      = 4;
    localparam int B_DEC      = 5;
    localparam int B_MODE     = 6;

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    localparam logic [6:0] MAX_M = 7'(MAX_MIN);
    localparam logic [5:0] MAX_S = 6'd59;

    // Wrapping field helpers used by inc/dec in EDIT.
    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] top);
        return (v >= top) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] wrap_dec(input logic [6:0] v, input logic [6:0] top);
        return (v == 7'd0) ? top : v - 7'd1;
    endfunction

    // -----------------------------------------------------------------------
    // Debounce
    // -----------------------------------------------------------------------
    logic [NB-1:0] btn_raw;
    logic [DW-1:0] deb_cnt [NB];
    logic [NB-1:0] armed;
    // A button that was already high while reset was asserted stays blocked
    // until it is seen low, so a held press never fires just because reset
    // re-armed it.
    logic [NB-1:0] blocked;
    logic [NB-1:0] accept;
    logic [NB-1:0] act;
    logic          ack_q;

    assign btn_raw = {mode_sel, dec, inc, edit_shift, start, edit, clear};

    always_comb begin
        accept = '0;
        for (int i = 0; i < NB; i++) begin
            accept[i] = btn_raw[i] & armed[i] & ~blocked[i] & ~reset &
                        (deb_cnt[i] == DEB_LAST);
        end
    end

    // Keep only the highest-priority accepted button; the rest are consumed.
    always_comb begin
        act = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (accept[i]) begin
                act    = '0;
                act[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
            armed   <= '1;
            blocked <= btn_raw;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (!btn_raw[i]) begin
                    deb_cnt[i] <= '0;
                    armed[i]   <= 1'b1;
                    blocked[i] <= 1'b0;
                end else if (accept[i]) begin
                    deb_cnt[i] <= '0;
                    armed[i]   <= 1'b0;
                end else if (armed[i] && !blocked[i] && deb_cnt[i] != DEB_LAST) begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q <= 1'b0;
        end else if (|accept) begin
            ack_q <= 1'b1;
        end else if (btn_raw == '0) begin
            ack_q <= 1'b0;
        end
    end

    assign btn_ack = ack_q | (|accept);

    // -----------------------------------------------------------------------
    // Prescaler and FSM next-state
    // -----------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic [2:0]    state_n;
    logic [6:0]    min_n;
    logic [5:0]    sec_n;
    logic          cu_n;
    logic          ep_n;
    logic          tick;
    logic          can_start;
    logic          expire;

    assign tick = (state == S_RUN) && (presc == TICK_LAST);

    // Starting would immediately over/underflow at the terminal value.
    assign can_start = count_up ? !((minutes == MAX_M) && (seconds == MAX_S))
                                : !((minutes == 7'd0) && (seconds == 6'd0));

    always_comb begin
        state_n = state;
        min_n   = minutes;
        sec_n   = seconds;
        cu_n    = count_up;
        ep_n    = edit_place;
        presc_n = '0;
        expire  = 1'b0;

        case (state)
            S_IDLE: begin
                if (act[B_EDIT]) begin
                    state_n = S_EDIT;
                end else if (act[B_START] && can_start) begin
                    state_n = S_RUN;
                end else if (act[B_MODE]) begin
                    cu_n = ~count_up;
                end
            end

            S_EDIT: begin
                if (act[B_EDIT]) begin
                    state_n = S_IDLE;
                end else if (act[B_SHIFT]) begin
                    ep_n = ~edit_place;
                end else if (act[B_INC]) begin
                    if (edit_place) min_n = wrap_inc(minutes, MAX_M);
                    else            sec_n = 6'(wrap_inc({1'b0, seconds}, {1'b0, MAX_S}));
                end else if (act[B_DEC]) begin
                    if (edit_place) min_n = wrap_dec(minutes, MAX_M);
                    else            sec_n = 6'(wrap_dec({1'b0, seconds}, {1'b0, MAX_S}));
                end
            end

            S_RUN: begin
                presc_n = tick ? '0 : presc + 1'b1;
                if (tick) begin
                    if (!count_up) begin
                        if (seconds != 6'd0) begin
                            sec_n = seconds - 6'd1;
                        end else begin
                            min_n = minutes - 7'd1;
                            sec_n = MAX_S;
                        end
                        expire = (minutes == 7'd0) && (seconds == 6'd1);
                    end else begin
                        if (seconds != MAX_S) begin
                            sec_n = seconds + 6'd1;
                        end else begin
                            min_n = minutes + 7'd1;
                            sec_n = 6'd0;
                        end
                        expire = (minutes == MAX_M) && (seconds == MAX_S - 6'd1);
                    end
                end
                // Reaching the terminal value takes precedence over a
                // simultaneous pause request.
                if (expire) begin
                    state_n = S_EXPIRED;
                end else if (act[B_START]) begin
                    state_n = S_PAUSED;
                end
            end

            S_PAUSED: begin
                if (act[B_START] && can_start) begin
                    state_n = S_RUN;
                end else if (act[B_EDIT]) begin
                    state_n = S_EDIT;
                end
            end

            S_EXPIRED: begin
                if (|act) begin
                    state_n = S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase

        if (act[B_CLEAR]) begin
            state_n = S_IDLE;
            min_n   = 7'd0;
            sec_n   = 6'd0;
            presc_n = '0;
        end

        // Every entry to RUN starts a fresh second.
        if (state_n == S_RUN && state != S_RUN) begin
            presc_n = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            minutes    <= 7'd0;
            seconds    <= 6'd0;
            count_up   <= 1'b0;
            edit_place <= 1'b1;
            presc      <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            minutes    <= min_n;
            seconds    <= sec_n;
            count_up   <= cu_n;
            edit_place <= ep_n;
            presc      <= presc_n;
            done       <= (state_n == S_EXPIRED) && (state != S_EXPIRED);
        end
    end

    assign alarm = (state == S_EXPIRED);

endmodule

// File: tb/tb_multi_mode_timer.sv
module tb_multi_mode_timer;

    localparam int TICK = 10;
    localparam int DEB  = 4;

    // Button vector bit positions
    localparam logic [6:0] B_CLEAR = 7'b0000001;
    localparam logic [6:0] B_EDIT  = 7'b0000010;
    localparam logic [6:0] B_START = 7'b0000100;
    localparam logic [6:0] B_SHIFT = 7'b0001000;
    localparam logic [6:0] B_INC   = 7'b0010000;
    localparam logic [6:0] B_DEC   = 7'b0100000;
    localparam logic [6:0] B_MODE  = 7'b1000000;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] b;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [2:0] state;
    logic       count_up, edit_place, done, alarm, btn_ack;

    int n_checks = 0;
    int n_fail   = 0;

    multi_mode_timer #(
        .TICK_CYCLES(TICK),
        .DEB_CYCLES (DEB),
        .MAX_MIN    (99)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (b[2]),
        .edit      (b[1]),
        .edit_shift(b[3]),
        .inc       (b[4]),
        .dec       (b[5]),
        .clear     (b[0]),
        .mode_sel  (b[6]),
        .minutes   (minutes),
        .seconds   (seconds),
        .state     (state),
        .count_up  (count_up),
        .edit_place(edit_place),
        .done      (done),
        .alarm     (alarm),
        .btn_ack   (btn_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold the given buttons just long enough to be accepted; the action
    // lands on the DEB-th rising edge. Returns at the following falling edge.
    task automatic press(input logic [6:0] m);
        @(negedge clk);
        b = m;
        repeat (DEB) @(posedge clk);
        @(negedge clk);
        b = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        b     = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_min",   minutes, 0);
        check("rst_sec",   seconds, 0);
        check("rst_state", state, 0);
        check("rst_cu",    count_up, 0);
        check("rst_ep",    edit_place, 1);
        check("rst_done",  done, 0);
        check("rst_alarm", alarm, 0);
        check("rst_ack",   btn_ack, 0);
        reset = 1'b0;
        wait_cycles(2);

        // Edit and wrap
        press(B_EDIT);
        check("edit_enter", state, 1);
        repeat (3) press(B_INC);
        check("edit_min3", minutes, 3);
        press(B_SHIFT);
        check("edit_ep0", edit_place, 0);
        press(B_DEC);
        check("edit_min", minutes, 3);
        check("edit_sec_wrap", seconds, 59);
        check("edit_state", state, 1);

        // Countdown 00:02
        press(B_CLEAR);
        check("clr_min", minutes, 0);
        check("clr_sec", seconds, 0);
        check("clr_state", state, 0);
        press(B_START);
        check("start_at_zero_ignored", state, 0);
        press(B_EDIT);
        repeat (2) press(B_INC);
        press(B_EDIT);
        check("cd_preset_sec", seconds, 2);
        check("cd_idle", state, 0);
        press(B_START);
        check("cd_run", state, 2);
        wait_cycles(TICK - 1);
        check("cd_pre_tick", seconds, 2);
        wait_cycles(1);
        check("cd_tick1_sec", seconds, 1);
        check("cd_tick1_state", state, 2);
        check("cd_tick1_done", done, 0);
        wait_cycles(TICK);
        check("cd_exp_sec", seconds, 0);
        check("cd_exp_min", minutes, 0);
        check("cd_exp_state", state, 4);
        check("cd_exp_done", done, 1);
        check("cd_exp_alarm", alarm, 1);
        wait_cycles(1);
        check("cd_done_pulse", done, 0);
        wait_cycles(5);
        check("cd_alarm_hold", alarm, 1);
        press(B_INC);
        check("cd_exp_to_idle", state, 0);
        check("cd_alarm_off", alarm, 0);
        check("cd_time_held", seconds, 0);

        // Pause at 01:00
        press(B_EDIT);
        press(B_SHIFT);
        press(B_INC);
        press(B_EDIT);
        check("ps_preset_min", minutes, 1);
        press(B_START);
        press(B_START);
        check("ps_paused", state, 3);
        check("ps_min", minutes, 1);
        check("ps_sec", seconds, 0);
        wait_cycles(20);
        check("ps_frozen_min", minutes, 1);
        check("ps_frozen_sec", seconds, 0);
        press(B_INC);
        check("ps_inc_ignored", minutes, 1);
        press(B_START);
        check("ps_resume", state, 2);
        wait_cycles(TICK - 1);
        check("ps_pre_tick", minutes, 1);
        wait_cycles(1);
        check("ps_tick_min", minutes, 0);
        check("ps_tick_sec", seconds, 59);
        press(B_CLEAR);
        check("ps_clear_state", state, 0);

        // Stopwatch limit at 99:59
        press(B_MODE);
        check("sw_cu", count_up, 1);
        press(B_EDIT);
        press(B_DEC);
        check("sw_min_wrap", minutes, 99);
        press(B_SHIFT);
        press(B_DEC);
        press(B_DEC);
        press(B_EDIT);
        check("sw_preset_sec", seconds, 58);
        press(B_START);
        wait_cycles(TICK);
        check("sw_min", minutes, 99);
        check("sw_sec", seconds, 59);
        check("sw_expired", state, 4);
        check("sw_done", done, 1);
        wait_cycles(15);
        check("sw_no_wrap_min", minutes, 99);
        check("sw_no_wrap_sec", seconds, 59);
        press(B_CLEAR);
        check("sw_clear_min", minutes, 0);
        check("sw_clear_state", state, 0);
        press(B_MODE);
        check("sw_cu_back", count_up, 0);

        // Debounce and priority
        press(B_EDIT);
        @(negedge clk);
        b = B_INC;
        repeat (DEB - 1) @(posedge clk);
        @(negedge clk);
        b = '0;
        wait_cycles(2);
        check("glitch_sec", seconds, 0);
        check("glitch_ack", btn_ack, 0);
        press(B_EDIT);
        press(B_EDIT | B_CLEAR);
        check("prio_clear", state, 0);
        press(B_EDIT);
        @(negedge clk);
        b = B_INC;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("hold_ack", btn_ack, 1);
        b = '0;
        wait_cycles(2);
        check("hold_one_inc", seconds, 1);
        check("hold_ack_clr", btn_ack, 0);
        press(B_START);
        check("edit_start_ign", state, 1);
        press(B_MODE);
        check("edit_mode_ign", count_up, 0);

        // Reset mid-run at 05:30
        repeat (29) press(B_INC);
        press(B_SHIFT);
        repeat (5) press(B_INC);
        press(B_EDIT);
        press(B_START);
        check("rr_run", state, 2);
        check("rr_min", minutes, 5);
        check("rr_sec", seconds, 30);
        b     = B_START;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rr_min0", minutes, 0);
        check("rr_sec0", seconds, 0);
        check("rr_idle", state, 0);
        wait_cycles(3 * DEB);
        check("rr_held_no_ack", btn_ack, 0);
        b = '0;
        wait_cycles(2);
        press(B_START);
        check("rr_repress_ack", btn_ack, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_mode_timer.md
MULTI_MODE_TIMER -- requirements
Module: multi_mode_timer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100_000_000: clk cycles per 1 s tick; legal range >=2.
REQ-002 SHALL have parameter DEB_CYCLES, default 25_000_000: cycles a button must stay high before it is accepted; legal range >=1.
REQ-003 SHALL have parameter MAX_MIN, default 99: highest minutes value; legal range 1..99.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port: clk  in  1  system clock; all logic on its rising edge.
REQ-006 Port: reset  in  1  synchronous active-high reset.
REQ-007 Ports: start, edit, edit_shift, inc, dec, clear, mode_sel  in  1 each  raw pushbuttons, active high.
REQ-008 Port: minutes  out  7  current minutes, binary, 0..MAX_MIN.
REQ-009 Port: seconds  out  6  current seconds, binary, 0..59.
REQ-010 Port: state  out  3  FSM state: IDLE=0, EDIT=1, RUN=2, PAUSED=3, EXPIRED=4.
REQ-011 Port: count_up  out  1  0 = countdown mode, 1 = stopwatch mode.
REQ-012 Port: edit_place  out  1  1 = minutes field selected, 0 = seconds field selected.
REQ-013 Port: done  out  1  one-cycle pulse on entry to EXPIRED.
REQ-014 Port: alarm  out  1  high for the whole time state is EXPIRED.
REQ-015 Port: btn_ack  out  1  high from the cycle a press is accepted until all buttons are low.

Function
REQ-016 Each button SHALL have its own counter; a press is accepted on the cycle the button has been high for DEB_CYCLES consecutive cycles.
REQ-017 Any low cycle SHALL clear that button's counter. A button SHALL be accepted at most once per press, and is re-armed only after it goes low.
REQ-018 If several buttons are accepted in the same cycle, only the highest-priority one SHALL act: clear > edit > start > edit_shift > inc > dec > mode_sel. The others are consumed with no effect.
REQ-019 clear SHALL act in every state: minutes and seconds go to 0, state goes to IDLE, prescaler goes to 0.
REQ-020 IDLE: edit -> EDIT.
REQ-021 IDLE: mode_sel toggles count_up.
REQ-022 IDLE: start -> RUN, except in countdown mode with time 00:00, where start is ignored.
REQ-023 EDIT: edit -> IDLE; edit_shift toggles edit_place.
REQ-024 EDIT, inc: the selected field increments, wrapping MAX_MIN->0 for minutes and 59->0 for seconds.
REQ-025 EDIT, dec: the selected field decrements, wrapping 0->MAX_MIN for minutes and 0->59 for seconds.
REQ-026 EDIT: start and mode_sel SHALL be ignored.
REQ-027 RUN: start -> PAUSED. PAUSED: start -> RUN. PAUSED: edit -> EDIT. All other buttons are ignored in RUN and PAUSED.
REQ-028 The prescaler SHALL count 0..TICK_CYCLES-1 only while in RUN and SHALL reset to 0 on every entry to RUN. A tick occurs on the cycle it wraps, so the first tick is TICK_CYCLES cycles after entry.
REQ-029 Countdown tick: if seconds>0, decrement seconds; otherwise decrement minutes and set seconds to 59.
REQ-030 Countdown: the tick that produces 00:00 SHALL also move the FSM to EXPIRED in that same cycle.
REQ-031 Stopwatch tick: if seconds<59, increment seconds; otherwise increment minutes and set seconds to 0.
REQ-032 Stopwatch: the tick that produces MAX_MIN:59 SHALL move the FSM to EXPIRED in that same cycle; the count never wraps.
REQ-033 Entry to EXPIRED SHALL assert done for exactly one cycle.
REQ-034 EXPIRED: any accepted button except clear -> IDLE with time held; clear behaves per REQ-019.
REQ-035 A tick and an accepted start in the same cycle SHALL both take effect: the time updates and the FSM goes to PAUSED.
REQ-036 Time SHALL change only on ticks, inc/dec, clear or reset.

Reset
REQ-037 On reset, in the next cycle: minutes=0, seconds=0, state=IDLE, count_up=0, edit_place=1, done=0, alarm=0, btn_ack=0.
REQ-038 On reset, all debounce counters and the prescaler SHALL clear, and button re-arm flags SHALL be set as if all buttons had been released.
REQ-039 Reset mid-press SHALL require the button to go low before it can be accepted again.

Verification (TICK_CYCLES=10, DEB_CYCLES=4, MAX_MIN=99)
REQ-040 Edit and wrap: edit, then inc x3 on minutes, then edit_shift, then dec x1 -> minutes=3, seconds=59, state=EDIT.
REQ-041 Countdown: set 00:02, then start -> seconds=1 at entry+10 cycles, 00:00 with state=EXPIRED and done pulse at +20, alarm high until the next press.
REQ-042 Pause: set 01:00 and start; at entry+5 press start -> state=PAUSED and time frozen; press start again -> first tick 10 cycles later gives 00:59.
REQ-043 Stopwatch limit: mode_sel in IDLE (count_up=1), preset 99:58, start -> 99:59 and EXPIRED after 10 cycles; no wrap.
REQ-044 Debounce and priority: a 3-cycle glitch on inc has no effect. edit and clear accepted in the same cycle -> clear wins and state=IDLE. Holding inc for 50 cycles -> exactly one increment.
REQ-045 Reset mid-run: assert reset at 05:30 in RUN -> next cycle 00:00 and IDLE. A start held through reset is not accepted until it has been released and pressed again.
